// File: rtl/bambu_mem_model_nch_pkg.sv
// Shared types and constants for the multi-channel Bambu memory responder.
package bambu_mem_model_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} chan_state_e;

  // Galois LFSR, x^16+x^14+x^13+x^11+1, right-shifting form.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Counter wide enough for the larger latency plus up to three jitter cycles.
  function automatic int lat_cnt_w(input int rd_lat, input int wr_lat);
    int m;
    m = (rd_lat > wr_lat) ? rd_lat : wr_lat;
    return $clog2(m + 4);
  endfunction

endpackage

// File: rtl/bambu_mem_model_nch_if.sv
// Master-side memory bus of the Bambu main core, one packed slice per channel.
interface bambu_mem_model_nch_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int SIZE_W = 4
);
  logic [NUM_CH-1:0]        Mout_oe_ram;
  logic [NUM_CH-1:0]        Mout_we_ram;
  logic [NUM_CH*ADDR_W-1:0] Mout_addr_ram;
  logic [NUM_CH*DATA_W-1:0] Mout_Wdata_ram;
  logic [NUM_CH*SIZE_W-1:0] Mout_data_ram_size;
  logic [NUM_CH*DATA_W-1:0] M_Rdata_ram;
  logic [NUM_CH-1:0]        M_DataRdy;

  modport master (
    output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    input  M_Rdata_ram, M_DataRdy
  );

  modport slave (
    input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    output M_Rdata_ram, M_DataRdy
  );
endinterface

// File: rtl/bambu_mem_model_nch_chan_fsm.sv
// Per-channel request acceptance, latency countdown, DataRdy pulse and
// sticky error flags. Optional MEM_MODEL_JITTER_EN adds 0-3 random cycles.
module bambu_mem_chan_fsm
  import bambu_mem_model_pkg::*;
#(
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1,
  parameter int CNT_W     = lat_cnt_w(READ_LAT, WRITE_LAT)
) (
  input  logic clock,
  input  logic reset,
  input  logic oe,
  input  logic we,
  input  logic in_win,
  output logic accept_rd,
  output logic accept_wr,
  output logic data_rdy,
  output logic err_conflict,
  output logic err_oow
);

  chan_state_e      state_q, state_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx, lat_tot, jit;
  logic             idle_req, accept, legacy_wr, conflict, oow;

  // Requests only count while idle and out of reset.
  assign idle_req  = reset && (state_q == IDLE);
  assign conflict  = idle_req && oe && we;
  assign accept    = idle_req && (oe ^ we) && in_win;
  assign oow       = idle_req && (oe ^ we) && !in_win;
  assign accept_rd = accept && oe;
  assign accept_wr = accept && we;
  assign legacy_wr = (WRITE_LAT == 0) && accept_wr;

`ifdef MEM_MODEL_JITTER_EN
  logic [15:0] lfsr_q;

  // LFSR advances once per accepted request; its LSBs stretch that request.
  always_ff @(posedge clock) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else if (accept) lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0);
  end

  assign jit = CNT_W'(lfsr_q[1:0]);
`else
  assign jit = '0;
`endif

  assign lat_tot  = (oe ? CNT_W'(READ_LAT) : CNT_W'(WRITE_LAT)) + jit;
  assign data_rdy = (state_q == DONE) || legacy_wr;

  // State and counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
    end
  end

  // Next state: DONE lands exactly LAT cycles after the accepting cycle.
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && !legacy_wr) begin
          if (lat_tot == CNT_W'(1)) begin
            state_nx = DONE;
          end else begin
            state_nx = BUSY;
            cnt_nx   = lat_tot - CNT_W'(2);
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_nx = DONE;
        else cnt_nx = cnt_q - CNT_W'(1);
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Sticky protocol-error flags, cleared only by reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      err_conflict <= 1'b0;
      err_oow      <= 1'b0;
    end else begin
      if (conflict) err_conflict <= 1'b1;
      if (oow) err_oow <= 1'b1;
    end
  end

endmodule

// File: rtl/bambu_mem_model_nch.sv
// Multi-channel off-chip memory responder for Bambu main cores: byte array
// mapped at base_addr, size-masked writes, per-channel latency engines.
// Define MEM_MODEL_JITTER_EN to add LFSR latency jitter in each channel.
module bambu_mem_model_nch
  import bambu_mem_model_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 8,
  parameter int SIZE_W    = 4,
  parameter int MEM_BYTES = 1,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   base_addr,
  bambu_mem_model_nch_if.slave bus,
  input  logic                init_we,
  input  logic [ADDR_W-1:0]   init_addr,
  input  logic [7:0]          init_data,
  output logic [NUM_CH-1:0]   err_conflict,
  output logic [NUM_CH-1:0]   err_oow
);

  localparam int NB     = DATA_W / 8;
  localparam int MIDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int CNT_W  = lat_cnt_w(READ_LAT, WRITE_LAT);
  localparam logic [ADDR_W:0] WIN_LEN = (ADDR_W+1)'(MEM_BYTES);

  logic [7:0]               mem [MEM_BYTES];
  logic [NUM_CH-1:0]        in_win, acc_rd, acc_wr, data_rdy;
  logic [ADDR_W:0]          addr_ext [NUM_CH];
  logic [ADDR_W:0]          off [NUM_CH];
  logic [DATA_W-1:0]        mask [NUM_CH];
  logic [ADDR_W:0]          byte_idx [NUM_CH][NB];
  logic                     byte_ok [NUM_CH][NB];
  logic [7:0]               wr_byte [NUM_CH][NB];
  logic [DATA_W-1:0]        rd_word_p0 [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] rdata_p1;

  // Bits below the access size are written; size >= DATA_W gives all ones.
  function automatic logic [DATA_W-1:0] size_mask(input logic [SIZE_W-1:0] sz);
    logic [DATA_W-1:0] m;
    for (int k = 0; k < DATA_W; k++) m[k] = (k < int'(sz));
    return m;
  endfunction

  // Window decode, byte footprint, read gather and write merge for every channel.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      addr_ext[i]   = {1'b0, bus.Mout_addr_ram[i*ADDR_W +: ADDR_W]};
      in_win[i]     = (addr_ext[i] >= {1'b0, base_addr}) &&
                      (addr_ext[i] < ({1'b0, base_addr} + WIN_LEN));
      off[i]        = addr_ext[i] - {1'b0, base_addr};
      mask[i]       = size_mask(bus.Mout_data_ram_size[i*SIZE_W +: SIZE_W]);
      rd_word_p0[i] = '0;
      for (int b = 0; b < NB; b++) begin
        byte_idx[i][b] = off[i] + (ADDR_W+1)'(b);
        byte_ok[i][b]  = byte_idx[i][b] < WIN_LEN;
        rd_word_p0[i][8*b +: 8] = byte_ok[i][b] ? mem[byte_idx[i][b][MIDX_W-1:0]] : 8'h00;
        wr_byte[i][b] = (bus.Mout_Wdata_ram[i*DATA_W + 8*b +: 8] & mask[i][8*b +: 8]) |
                        (rd_word_p0[i][8*b +: 8] & ~mask[i][8*b +: 8]);
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    bambu_mem_chan_fsm #(
      .READ_LAT  (READ_LAT),
      .WRITE_LAT (WRITE_LAT),
      .CNT_W     (CNT_W)
    ) u_fsm (
      .clock        (clock),
      .reset        (reset),
      .oe           (bus.Mout_oe_ram[i]),
      .we           (bus.Mout_we_ram[i]),
      .in_win       (in_win[i]),
      .accept_rd    (acc_rd[i]),
      .accept_wr    (acc_wr[i]),
      .data_rdy     (data_rdy[i]),
      .err_conflict (err_conflict[i]),
      .err_oow      (err_oow[i])
    );
  end

  // Array update: backdoor first, then channels in index order so the
  // highest channel wins a shared byte and any channel beats the backdoor.
  always_ff @(posedge clock) begin
    if (init_we && ({1'b0, init_addr} < WIN_LEN)) mem[init_addr[MIDX_W-1:0]] <= init_data;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int b = 0; b < NB; b++) begin
        if (acc_wr[i] && byte_ok[i][b]) mem[byte_idx[i][b][MIDX_W-1:0]] <= wr_byte[i][b];
      end
    end
  end

  // Read data is captured when the request is accepted and held until the next read.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rdata_p1 <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (acc_rd[i]) rdata_p1[i*DATA_W +: DATA_W] <= rd_word_p0[i];
      end
    end
  end

  assign bus.M_Rdata_ram = rdata_p1;
  assign bus.M_DataRdy   = data_rdy;

endmodule

// File: tb/tb_bambu_mem_model_nch.sv
// Directed bench for bambu_mem_model_nch: 2 channels, 16-bit data, 16-byte window at 0x100.
module tb_bambu_mem_model_nch;

  localparam int NUM_CH    = 2;
  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 16;
  localparam int SIZE_W    = 5;
  localparam int MEM_BYTES = 16;
  localparam int READ_LAT  = 2;
  localparam int WRITE_LAT = 1;

  logic              clock = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] base_addr;
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [7:0]        init_data;
  logic [NUM_CH-1:0] err_conflict;
  logic [NUM_CH-1:0] err_oow;

  int n_cmp  = 0;
  int n_fail = 0;

  bambu_mem_model_nch_if #(
    .NUM_CH (NUM_CH), .ADDR_W (ADDR_W), .DATA_W (DATA_W), .SIZE_W (SIZE_W)
  ) bus ();

  bambu_mem_model_nch #(
    .NUM_CH (NUM_CH), .ADDR_W (ADDR_W), .DATA_W (DATA_W), .SIZE_W (SIZE_W),
    .MEM_BYTES (MEM_BYTES), .READ_LAT (READ_LAT), .WRITE_LAT (WRITE_LAT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .base_addr    (base_addr),
    .bus          (bus),
    .init_we      (init_we),
    .init_addr    (init_addr),
    .init_data    (init_data),
    .err_conflict (err_conflict),
    .err_oow      (err_oow)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    init_we   = 1'b1;
    init_addr = a;
    init_data = d;
    step();
    init_we   = 1'b0;
  endtask

  task automatic set_req(input int ch, input logic oe, input logic we,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                         input logic [SIZE_W-1:0] sz);
    bus.Mout_oe_ram[ch] = oe;
    bus.Mout_we_ram[ch] = we;
    bus.Mout_addr_ram[ch*ADDR_W +: ADDR_W] = a;
    bus.Mout_Wdata_ram[ch*DATA_W +: DATA_W] = wd;
    bus.Mout_data_ram_size[ch*SIZE_W +: SIZE_W] = sz;
  endtask

  task automatic drop_req(input int ch);
    bus.Mout_oe_ram[ch] = 1'b0;
    bus.Mout_we_ram[ch] = 1'b0;
  endtask

  // Read with READ_LAT=2: DataRdy in cycle c+2 only, data held afterwards.
  task automatic do_read(input string tag, input int ch, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] exp);
    set_req(ch, 1'b1, 1'b0, a, '0, '0);
    chk({tag, "_rdy_c0"}, 64'(bus.M_DataRdy), 64'(0));
    step();
    chk({tag, "_rdy_c1"}, 64'(bus.M_DataRdy), 64'(0));
    step();
    chk({tag, "_rdy_c2"}, 64'(bus.M_DataRdy), 64'(2'b01 << ch));
    chk({tag, "_data"}, 64'(bus.M_Rdata_ram[ch*DATA_W +: DATA_W]), 64'(exp));
    drop_req(ch);
    step();
    chk({tag, "_rdy_c3"}, 64'(bus.M_DataRdy), 64'(0));
    chk({tag, "_hold"}, 64'(bus.M_Rdata_ram[ch*DATA_W +: DATA_W]), 64'(exp));
  endtask

  // Write with WRITE_LAT=1: DataRdy in cycle c+1 only.
  task automatic do_write(input string tag, input int ch, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] wd, input logic [SIZE_W-1:0] sz);
    set_req(ch, 1'b0, 1'b1, a, wd, sz);
    chk({tag, "_rdy_c0"}, 64'(bus.M_DataRdy), 64'(0));
    step();
    chk({tag, "_rdy_c1"}, 64'(bus.M_DataRdy), 64'(2'b01 << ch));
    drop_req(ch);
    step();
    chk({tag, "_rdy_c2"}, 64'(bus.M_DataRdy), 64'(0));
  endtask

  initial begin
    int seen;
    reset     = 1'b0;
    base_addr = 11'h100;
    init_we   = 1'b0;
    init_addr = '0;
    init_data = '0;
    bus.Mout_oe_ram        = '0;
    bus.Mout_we_ram        = '0;
    bus.Mout_addr_ram      = '0;
    bus.Mout_Wdata_ram     = '0;
    bus.Mout_data_ram_size = '0;
    step();
    preload(11'd0, 8'h11);
    preload(11'd1, 8'h22);
    preload(11'd2, 8'h33);
    preload(11'd3, 8'h44);
    preload(11'd4, 8'h66);
    preload(11'd5, 8'h77);
    preload(11'd8, 8'hFF);
    preload(11'd9, 8'hFF);
    preload(11'd15, 8'h5A);

    chk("rst_rdy", 64'(bus.M_DataRdy), 64'(0));
    chk("rst_rdata", 64'(bus.M_Rdata_ram), 64'(0));
    chk("rst_conflict", 64'(err_conflict), 64'(0));
    chk("rst_oow", 64'(err_oow), 64'(0));
    reset = 1'b1;
    step();

    do_read("rd_0x102", 0, 11'h102, 16'h4433);

    do_write("wr_mask", 0, 11'h108, 16'h1234, 5'd8);
    do_read("rd_mask", 1, 11'h108, 16'hFF34);

    set_req(0, 1'b0, 1'b1, 11'h10A, 16'h00AA, 5'd16);
    set_req(1, 1'b0, 1'b1, 11'h10A, 16'h0055, 5'd16);
    step();
    chk("contend_rdy", 64'(bus.M_DataRdy), 64'(2'b11));
    drop_req(0);
    drop_req(1);
    step();
    chk("contend_rdy_off", 64'(bus.M_DataRdy), 64'(0));
    do_read("rd_contend", 0, 11'h10A, 16'h0055);

    set_req(1, 1'b1, 1'b0, 11'h110, '0, '0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.M_DataRdy != '0) seen++;
      step();
    end
    chk("oow_no_rdy", 64'(seen), 64'(0));
    chk("oow_flags", 64'(err_oow), 64'(2'b10));
    drop_req(1);
    step();

    do_read("rd_edge", 0, 11'h10F, 16'h005A);

    set_req(0, 1'b1, 1'b0, 11'h0FF, '0, '0);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.M_DataRdy != '0) seen++;
      step();
    end
    chk("below_no_rdy", 64'(seen), 64'(0));
    chk("below_flags", 64'(err_oow), 64'(2'b11));
    drop_req(0);
    step();

    set_req(0, 1'b1, 1'b1, 11'h100, 16'hDEAD, 5'd16);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.M_DataRdy != '0) seen++;
      step();
    end
    chk("conf_no_rdy", 64'(seen), 64'(0));
    chk("conf_flag", 64'(err_conflict), 64'(2'b01));
    drop_req(0);
    step();
    do_read("rd_conf", 1, 11'h100, 16'h2211);

    set_req(0, 1'b1, 1'b0, 11'h104, '0, '0);
    set_req(1, 1'b0, 1'b1, 11'h104, 16'hBEEF, 5'd16);
    step();
    chk("rw_rdy_c1", 64'(bus.M_DataRdy), 64'(2'b10));
    drop_req(1);
    step();
    chk("rw_rdy_c2", 64'(bus.M_DataRdy), 64'(2'b01));
    chk("rw_old", 64'(bus.M_Rdata_ram[15:0]), 64'(16'h7766));
    drop_req(0);
    step();
    do_read("rd_rw_new", 0, 11'h104, 16'hBEEF);

    set_req(0, 1'b0, 1'b1, 11'h106, 16'h1111, 5'd16);
    init_we   = 1'b1;
    init_addr = 11'd6;
    init_data = 8'h99;
    step();
    init_we = 1'b0;
    chk("init_rdy", 64'(bus.M_DataRdy), 64'(2'b01));
    drop_req(0);
    step();
    do_read("rd_init", 1, 11'h106, 16'h1111);

    set_req(0, 1'b1, 1'b0, 11'h102, '0, '0);
    step();
    reset = 1'b0;
    drop_req(0);
    chk("mid_rdy_c1", 64'(bus.M_DataRdy), 64'(0));
    step();
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.M_DataRdy != '0) seen++;
      step();
    end
    chk("mid_no_rdy", 64'(seen), 64'(0));
    chk("mid_conflict", 64'(err_conflict), 64'(0));
    chk("mid_oow", 64'(err_oow), 64'(0));
    chk("mid_rdata", 64'(bus.M_Rdata_ram), 64'(0));
    do_read("rd_after_rst", 0, 11'h100, 16'h2211);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
